// File: rtl/fetch_queue.sv
// Fetch stage with a decoupling instruction queue: keeps up to DEPTH requests in flight and discards stale responses after a redirect.
// Optional same-cycle response bypass to decode is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int                ADDR_W   = 16,
    parameter int                INST_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 2,
    parameter logic [INST_W-1:0] NOP_INST = 16'h0800
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_addr,
    input  logic                     halt,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_ready,
    input  logic                     imem_rvalid,
    input  logic [INST_W-1:0]        imem_rdata,
    input  logic                     imem_err,
    output logic                     dec_valid,
    output logic [INST_W-1:0]        dec_inst,
    output logic [ADDR_W-1:0]        dec_pc,
    output logic [ADDR_W-1:0]        dec_pc_next,
    input  logic                     dec_ready,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              err_q, err_d;

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

    logic credit_ok;
    logic req_accept;
    logic rsp_drop;
    logic rsp_keep;
    logic fifo_empty;
    logic bypass_hit;
    logic bypass_take;
    logic fifo_push;
    logic fifo_pop;

    // Occupancy plus outstanding requests never exceeds DEPTH, so a kept response always has a slot.
    assign credit_ok  = ({1'b0, count_q} + {1'b0, inflight_q}) < (CNT_W + 1)'(DEPTH);
    assign imem_req   = rst_n & ~halt & ~redirect_valid & credit_ok;
    assign req_accept = imem_req & imem_ready;
    assign imem_addr  = pc_q;

    assign rsp_drop   = imem_rvalid & (drop_q != '0);
    assign rsp_keep   = imem_rvalid & (drop_q == '0) & ~redirect_valid;
    assign fifo_empty = (count_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_hit = fifo_empty & rsp_keep;
`else
    assign bypass_hit = 1'b0;
`endif
    assign bypass_take = bypass_hit & dec_ready;

    assign fifo_push  = rsp_keep & ~bypass_take;
    assign fifo_pop   = ~fifo_empty & dec_ready & ~redirect_valid;

    always_comb begin
        dec_valid = ~fifo_empty;
        dec_inst  = inst_mem_q[rd_ptr_q];
        dec_pc    = pc_mem_q[rd_ptr_q];
        if (bypass_hit) begin
            dec_valid = 1'b1;
            dec_inst  = imem_rdata;
            dec_pc    = rsp_pc_q;
        end
        if (!dec_valid) begin
            dec_inst = NOP_INST;
            dec_pc   = pc_q;
        end
    end

    assign dec_pc_next = dec_pc + ADDR_W'(PC_INC);
    assign err         = err_q;
    assign count       = count_q;

    // Responses come back in order, so the PC of the next kept response is tracked as a running address.
    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q - CNT_W'(imem_rvalid);
        drop_d     = drop_q;
        err_d      = err_q | (rsp_keep & imem_err);

        if (redirect_valid) begin
            pc_d     = redirect_addr;
            rsp_pc_d = redirect_addr;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            drop_d   = inflight_q - CNT_W'(imem_rvalid);
        end else begin
            if (req_accept) begin
                pc_d       = pc_q + ADDR_W'(PC_INC);
                inflight_d = inflight_q + CNT_W'(1) - CNT_W'(imem_rvalid);
            end
            if (rsp_drop) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + ADDR_W'(PC_INC);
            end
            if (fifo_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: entries are only read while count marks them valid.
    always_ff @(posedge clk) begin
        if (fifo_push && !redirect_valid) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: a memory model feeds responses and a monitor compares decode output against expected order.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        halt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        imem_err;
    logic        dec_valid;
    logic [15:0] dec_inst;
    logic [15:0] dec_pc;
    logic [15:0] dec_pc_next;
    logic        dec_ready;
    logic        err;
    logic [2:0]  count;

    fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt           (halt),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .imem_err       (imem_err),
        .dec_valid      (dec_valid),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_pc_next    (dec_pc_next),
        .dec_ready      (dec_ready),
        .err            (err),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        bit          stale;
        int          cyc;
    } memEntry_t;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] pc;
    } expEntry_t;

    memEntry_t   memQ[$];
    expEntry_t   sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cycleNum = 0;
    bit          running = 1'b0;
    bit          pending = 1'b0;
    bit          respNow = 1'b0;
    bit          errPending = 1'b0;
    bit          errModel = 1'b0;
    logic [15:0] pcModel = 16'h0000;
    int          pReady, pResp, pDec, pRedir, pHalt, pErr;

    function automatic logic [15:0] memData(input logic [15:0] a);
        return (a * 16'h03B1) ^ 16'h5A5A;
    endfunction

    function automatic bit chance(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleNum);
        end
    endtask

    // One cycle of stimulus: memory model returns the oldest eligible request and expected entries are queued.
    task automatic applyStimulus();
        memEntry_t e;
        cycleNum++;
        pending        = 1'b0;
        respNow        = 1'b0;
        redirect_valid = chance(pRedir);
        redirect_addr  = 16'($urandom) & 16'hFFFE;
        halt           = chance(pHalt);
        imem_ready     = chance(pReady);
        dec_ready      = chance(pDec);
        imem_rvalid    = 1'b0;
        imem_rdata     = 16'h0000;
        imem_err       = 1'b0;
        if (memQ.size() > 0 && memQ[0].cyc < cycleNum && chance(pResp)) begin
            e           = memQ.pop_front();
            respNow     = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata  = memData(e.addr);
            imem_err    = chance(pErr);
            if (!e.stale && !redirect_valid) begin
                sbq.push_back('{inst: memData(e.addr), pc: e.addr});
                pending = 1'b1;
                if (imem_err) errPending = 1'b1;
            end
        end
        if (redirect_valid) begin
            foreach (memQ[i]) memQ[i].stale = 1'b1;
            sbq.delete();
            pcModel = redirect_addr;
        end
    endtask

    // Monitor: compares the handshake, credit rule and sticky error against the model each cycle.
    int        monCnt;
    bit        monValid;
    bit        monReq;
    expEntry_t monHead;
    always @(negedge clk) begin
        if (running) begin
            monCnt = sbq.size() - int'(pending);
            if (!redirect_valid) begin
                checkOutput("count", 32'(count), 32'(monCnt));
                monValid = BYP ? (sbq.size() > 0) : (monCnt > 0);
                checkOutput("dec_valid", 32'(dec_valid), 32'(monValid));
                if (dec_valid && dec_ready && sbq.size() > 0) begin
                    monHead = sbq.pop_front();
                    checkOutput("dec_inst", 32'(dec_inst), 32'(monHead.inst));
                    checkOutput("dec_pc", 32'(dec_pc), 32'(monHead.pc));
                    checkOutput("dec_pc_next", 32'(dec_pc_next), 32'(monHead.pc + 16'd2));
                end
                if (!dec_valid) checkOutput("dec_inst_nop", 32'(dec_inst), 32'h0800);
            end
            monReq = !halt && !redirect_valid && (monCnt + memQ.size() + int'(respNow) < 4);
            checkOutput("imem_req", 32'(imem_req), 32'(monReq));
            if (imem_req) checkOutput("imem_addr", 32'(imem_addr), 32'(pcModel));
            if (imem_req && imem_ready) begin
                memQ.push_back('{addr: pcModel, stale: 1'b0, cyc: cycleNum});
                pcModel = pcModel + 16'd2;
            end
            checkOutput("err", 32'(err), 32'(errModel));
            errModel   = errModel | errPending;
            errPending = 1'b0;
        end
    end

    task automatic setProb(input int r, input int rs, input int d, input int rd, input int h, input int e);
        pReady = r; pResp = rs; pDec = d; pRedir = rd; pHalt = h; pErr = e;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            applyStimulus();
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 16'h0000;
        halt           = 1'b0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 16'h0000;
        imem_err       = 1'b0;
        dec_ready      = 1'b0;
        setProb(100, 100, 100, 0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_imem_req", 32'(imem_req), 32'h0);
        checkOutput("rst_dec_valid", 32'(dec_valid), 32'h0);
        checkOutput("rst_dec_inst", 32'(dec_inst), 32'h0800);
        checkOutput("rst_dec_pc", 32'(dec_pc), 32'h0000);
        checkOutput("rst_count", 32'(count), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);

        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        running = 1'b1;
        applyStimulus();
        runCycles(39);

        setProb(100, 100, 0, 0, 0, 0);
        runCycles(20);
        @(negedge clk);
        checkOutput("bp_count_full", 32'(count), 32'h4);
        checkOutput("bp_req_low", 32'(imem_req), 32'h0);

        setProb(100, 100, 100, 0, 0, 0);
        runCycles(10);

        setProb(70, 60, 60, 4, 10, 5);
        runCycles(1500);

        setProb(100, 100, 100, 0, 100, 0);
        for (int i = 0; i < 64 && (memQ.size() > 0 || sbq.size() > 0); i++) runCycles(1);
        runCycles(1);
        if (memQ.size() > 0 || sbq.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", memQ.size() + sbq.size());
        end
        @(negedge clk);
        checkOutput("drain_count", 32'(count), 32'h0);
        checkOutput("drain_dec_valid", 32'(dec_valid), 32'h0);
        checkOutput("halt_req_low", 32'(imem_req), 32'h0);

        setProb(100, 100, 100, 0, 0, 0);
        runCycles(10);

        @(posedge clk);
        #1;
        running     = 1'b0;
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        checkOutput("rst2_err", 32'(err), 32'h0);
        checkOutput("rst2_count", 32'(count), 32'h0);
        checkOutput("rst2_imem_req", 32'(imem_req), 32'h0);
        checkOutput("rst2_dec_valid", 32'(dec_valid), 32'h0);
        checkOutput("rst2_dec_inst", 32'(dec_inst), 32'h0800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
